// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and frame constants.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEFAULT_BAUD_DIV = 868;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned FRAME_BITS       = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wp;
  logic [DEPTH_LOG2:0] rp;
  logic                do_push;
  logic                do_pop;

  // Pointers differ only in the wrap bit exactly when every slot is occupied.
  assign full     = (wp ^ rp) == {1'b1, {DEPTH_LOG2{1'b0}}};
  assign empty    = (wp == rp);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count    = wp - rp;
  assign pop_data = mem[rp[DEPTH_LOG2-1:0]];

  // NOTE: storage has no reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp[DEPTH_LOG2-1:0]] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed from a byte FIFO; tx is a registered output, idle high.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned BAUD_DIV        = DEFAULT_BAUD_DIV,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ready,
  output logic                       tx,
  output logic                       tx_busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       overflow
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_d;
  logic        baud_tc;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  head;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign wr_ready = !full;
  assign tx_busy  = (state_q != IDLE) || !empty;
  assign baud_tc  = (baud_q == BAUD_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_tc ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tc) state_d = DATA;
      end
      DATA: begin
        if (baud_tc) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        // Back-to-back frames: reload straight into START with no idle bit time.
        if (baud_tc) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = head;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is computed from the next state so the pin register lines up with the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx      <= tx_d;
      if (wr_valid && full) overflow <= 1'b1;
    end
  end

endmodule
